uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame; legal range 5..8.
REQ-002 Parameter SB_TICK, default 16, number of s_tick periods in the stop bit; legal values 16, 24, 32.
REQ-003 clk  input  1  system clock; all flops clock on its rising edge.
REQ-004 reset_n  input  1  reset; one clock, asynchronous assertion, active-low.
REQ-005 rx  input  1  serial line; asynchronous to clk; idles high.
REQ-006 s_tick  input  1  one-clk pulse at 16x the baud rate.
REQ-007 rd_uart  input  1  consumer acknowledge; pops the holding register.
REQ-008 dout  output  8  last received data; right-aligned; bits above DBIT-1 are zero.
REQ-009 rx_valid  output  1  holding register contains unread data.
REQ-010 rx_done_tick  output  1  one-clk pulse when a frame completes.
REQ-011 frame_err  output  1  stop-bit error flag of the frame held in dout.
REQ-012 overrun  output  1  sticky flag: an unread frame was overwritten.

Function
REQ-013 rx shall pass through a two-flop synchronizer before any use; all rx references below mean the synchronized value.
REQ-014 The FSM shall use the states idle, start, data and stop; the tick counter s and the bit counter n shall advance only on cycles where s_tick=1.
REQ-015 idle: the FSM shall go to start with s=0 only on a falling edge (previous sample 1, current sample 0); a line held low (break) shall never start a frame.
REQ-016 start: at s==7, rx=0 goes to data with s=0, n=0; rx=1 returns to idle as a glitch, with no flags and no output change.
REQ-017 data: rx shall be sampled at s==13, 14 and 15; at s==15 the 2-of-3 majority shall be shifted in LSB-first, s shall clear, and n==DBIT-1 goes to stop, otherwise n increments.
REQ-018 stop: the 2-of-3 majority at s==13..15 is the stop value; at s==SB_TICK-1 the FSM shall return to idle and complete the frame.
REQ-019 Completion shall, in the same cycle: pulse rx_done_tick; load dout; load frame_err = NOT stop value; set rx_valid.
REQ-020 Frames with a framing error shall still be delivered to dout.
REQ-021 rd_uart with rx_valid=1 shall clear rx_valid and overrun on the next edge; rd_uart with rx_valid=0 shall be ignored.
REQ-022 On completion with rx_valid=1 and rd_uart=0, the FSM shall set overrun and overwrite dout/frame_err with the new frame.
REQ-023 When completion and rd_uart coincide, rx_valid shall remain 1 holding the new frame, and overrun shall not be set.
REQ-024 s_tick gaps of any length shall only stall the counters; no state shall be lost.
REQ-025 Latency from the stop-bit sample window to rx_done_tick = SB_TICK-16 ticks + 1 clk.

Reset
REQ-026 While reset_n=0: state=idle; s, n and the shift register = 0; synchronizer flops = 1; dout = 0; rx_valid, rx_done_tick, frame_err and overrun = 0.
REQ-027 Reset asserted mid-frame shall abandon the frame without a done pulse; after release, reception shall restart only on a new falling edge.

Structure
REQ-028 Package uart_pkg shall hold the state encoding localparams, the OVERSAMPLE=16 constant and the DBIT/SB_TICK defaults shared with uart_tx.
REQ-029 The synchronizer shall be a separate sub-module, uart_sync2 (2-FF, reset value 1); all other logic stays in uart_rx.

Verification
REQ-030 s_tick every 4 clk; send 0xA5 with 8N1 -> one rx_done_tick; dout=0xA5; rx_valid=1; frame_err=0; overrun=0.
REQ-031 Low pulse of 5 ticks on rx while in idle -> return to idle; no rx_done_tick; outputs unchanged.
REQ-032 Send 0x3C with stop bit driven 0 -> dout=0x3C, frame_err=1; line held low afterwards -> no new frame until rx goes high then low again.
REQ-033 Send 0x11 then 0x22 with no rd_uart -> dout=0x22, overrun=1; rd_uart -> rx_valid=0, overrun=0.
REQ-034 DBIT=7, send 0x55 with one data-bit sample (tick 14) glitched -> majority vote gives dout=0x55; rd_uart pulsed on the exact completion cycle of the next frame 0x7F -> rx_valid=1, dout=0x7F, overrun=0.
REQ-035 reset_n pulsed low during data bit 4 -> all outputs 0; the next full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: oversampling ratio, frame defaults, FSM encoding
// and the 2-of-3 majority helper used by the receiver.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } rx_state_t;

  // Tick indices inside one oversampled bit: mid-start check and the three data samples
  localparam logic [4:0] S_MID  = 5'(OVERSAMPLE / 2 - 1);
  localparam logic [4:0] S_SMP0 = 5'(OVERSAMPLE - 3);
  localparam logic [4:0] S_SMP1 = 5'(OVERSAMPLE - 2);
  localparam logic [4:0] S_SMP2 = 5'(OVERSAMPLE - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle-high level so reset release never looks like a start edge.
module uart_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Metastability filter chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver with majority-vote sampling, a one-entry
// holding register, framing-error and overrun reporting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       s_tick,
  input  logic       rd_uart,
  output logic [7:0] dout,
  output logic       rx_valid,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [2:0] N_LAST     = 3'(DBIT - 1);
  localparam logic [4:0] S_STOP_END = 5'(SB_TICK - 1);

  logic            w_rx;
  logic            w_maj;
  logic            w_stop_val;
  logic            w_complete;
  logic            w_pop;
  logic [7:0]      w_dout_ext;

  rx_state_t       r_state;
  logic [4:0]      r_s;
  logic [2:0]      r_n;
  logic [DBIT-1:0] r_shift;
  logic [1:0]      r_smp;
  logic            r_stop_val;
  logic            r_rx_prev;
  logic [7:0]      r_dout;
  logic            r_valid;
  logic            r_done;
  logic            r_ferr;
  logic            r_ovr;

  uart_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (rx),
    .o_q     (w_rx)
  );

  assign w_maj      = maj3(r_smp[0], r_smp[1], w_rx);
  assign w_complete = (r_state == STOP) && s_tick && (r_s == S_STOP_END);
  assign w_pop      = rd_uart && r_valid;

  // With SB_TICK=16 the stop vote and completion land on the same tick
  always_comb begin
    w_stop_val = r_stop_val;
    if (r_s == S_SMP2) begin
      w_stop_val = w_maj;
    end else begin
      w_stop_val = r_stop_val;
    end
  end

  // Right-align the received word into the 8-bit output
  always_comb begin
    w_dout_ext = 8'h00;
    w_dout_ext[DBIT-1:0] = r_shift;
  end

  // Receive FSM, counters and registered consumer-side outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_s        <= 5'd0;
      r_n        <= 3'd0;
      r_shift    <= '0;
      r_smp      <= 2'b00;
      r_stop_val <= 1'b0;
      r_rx_prev  <= 1'b1;
      r_dout     <= 8'h00;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_rx_prev <= w_rx;
      r_done    <= 1'b0;

      if (w_complete) begin
        r_done  <= 1'b1;
        r_dout  <= w_dout_ext;
        r_ferr  <= ~w_stop_val;
        r_valid <= 1'b1;
        if (w_pop) begin
          r_ovr <= 1'b0;
        end else if (r_valid) begin
          r_ovr <= 1'b1;
        end else begin
          r_ovr <= r_ovr;
        end
      end else if (w_pop) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end

      case (r_state)
        IDLE: begin
          if (r_rx_prev && !w_rx) begin
            r_state <= START;
            r_s     <= 5'd0;
          end else begin
            r_state <= IDLE;
          end
        end
        START: begin
          if (s_tick) begin
            if (r_s == S_MID) begin
              r_s <= 5'd0;
              r_n <= 3'd0;
              r_state <= w_rx ? IDLE : DATA;
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (r_s == S_SMP0) r_smp[0] <= w_rx;
            if (r_s == S_SMP1) r_smp[1] <= w_rx;
            if (r_s == S_SMP2) begin
              r_shift <= {w_maj, r_shift[DBIT-1:1]};
              r_s     <= 5'd0;
              if (r_n == N_LAST) begin
                r_state <= STOP;
              end else begin
                r_n <= r_n + 3'd1;
              end
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (r_s == S_SMP0) r_smp[0] <= w_rx;
            if (r_s == S_SMP1) r_smp[1] <= w_rx;
            if (r_s == S_SMP2) r_stop_val <= w_maj;
            if (r_s == S_STOP_END) begin
              r_state <= IDLE;
              r_s     <= 5'd0;
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_s     <= 5'd0;
        end
      endcase
    end
  end

  assign dout         = r_dout;
  assign rx_valid     = r_valid;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
  assign overrun      = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8-bit instance and a 7-bit instance share
// clock, tick and reset; frames are bit-banged phase-locked to s_tick.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_tick;
  logic       rx1, rx2, rd1, rd2;
  logic [7:0] dout1, dout2;
  logic       valid1, valid2, done1, done2, ferr1, ferr2, ovr1, ovr2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done1_cnt = 0;
  int done2_cnt = 0;
  int done1_cyc = 0;
  int last_m = 0;

  uart_rx #(.DBIT(8), .SB_TICK(16)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .rx(rx1), .s_tick(s_tick), .rd_uart(rd1),
    .dout(dout1), .rx_valid(valid1), .rx_done_tick(done1), .frame_err(ferr1), .overrun(ovr1)
  );

  uart_rx #(.DBIT(7), .SB_TICK(16)) u_dut7 (
    .clk(clk), .reset_n(reset_n), .rx(rx2), .s_tick(s_tick), .rd_uart(rd2),
    .dout(dout2), .rx_valid(valid2), .rx_done_tick(done2), .frame_err(ferr2), .overrun(ovr2)
  );

  initial forever #5 clk = ~clk;

  // s_tick every fourth clock, driven on the falling edge
  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      s_tick = ((cyc % 4) == 0);
    end
  end

  // Count done pulses and remember when the 8-bit receiver completed
  initial forever begin
    @(negedge clk);
    #1;
    if (done1 === 1'b1) begin
      done1_cnt++;
      done1_cyc = cyc;
    end
    if (done2 === 1'b1) done2_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx1 = v; else rx2 = v;
  endtask

  task automatic set_rd(input int sel, input logic v);
    if (sel == 0) rd1 = v; else rd2 = v;
  endtask

  task automatic pulse_rd(input int sel);
    set_rd(sel, 1'b1);
    step(1);
    set_rd(sel, 1'b0);
    step(1);
  endtask

  // 64 clocks per bit; data bit samples read offsets 21/25/29, completion is sampled at stop offset 31
  task automatic send_frame(input int sel, input logic [7:0] data, input int nbits, input logic stop_v,
                            input int glitch_bit, input logic rd_at_done, input int abort_bit);
    logic b;
    step(1);
    while ((cyc % 4) != 1) step(1);
    last_m = cyc;
    for (int k = 0; k < nbits + 2; k++) begin
      if (k == 0) b = 1'b0;
      else if (k == nbits + 1) b = stop_v;
      else b = data[k-1];
      for (int i = 0; i < 64; i++) begin
        if (abort_bit >= 0 && k == abort_bit + 1 && i == 10) begin
          reset_n = 1'b0;
          step(1);
          return;
        end
        set_rx(sel, (glitch_bit >= 0 && k == glitch_bit + 1 && i == 25) ? ~b : b);
        if (rd_at_done && k == nbits + 1 && i == 31) set_rd(sel, 1'b1);
        if (rd_at_done && k == nbits + 1 && i == 32) set_rd(sel, 1'b0);
        step(1);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx1 = 1'b1; rx2 = 1'b1; rd1 = 1'b0; rd2 = 1'b0;
    step(3);
    checks++; if (dout1 !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout1); end
    checks++; if ({valid1, done1, ferr1, ovr1} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {valid1, done1, ferr1, ovr1}); end
    checks++; if ({dout2, valid2, ovr2} !== 10'd0) begin errors++; $display("FAIL reset_dut7 got %h exp 0", {dout2, valid2, ovr2}); end
    reset_n = 1'b1;
    step(4);
  endtask

  task automatic test_basic();
    int d0;
    d0 = done1_cnt;
    send_frame(0, 8'hA5, 8, 1'b1, -1, 1'b0, -1);
    step(8);
    checks++; if (done1_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_cnt got %0d exp 1", done1_cnt - d0); end
    checks++; if (dout1 !== 8'hA5) begin errors++; $display("FAIL basic_dout got %h exp a5", dout1); end
    checks++; if ({valid1, ferr1, ovr1} !== 3'b100) begin errors++; $display("FAIL basic_flags got %b exp 100", {valid1, ferr1, ovr1}); end
    checks++; if (done1_cyc !== last_m + 96 + 64 * 8) begin errors++; $display("FAIL basic_latency got %0d exp %0d", done1_cyc, last_m + 96 + 64 * 8); end
  endtask

  task automatic test_glitch_start();
    int d0;
    d0 = done1_cnt;
    step(1);
    while ((cyc % 4) != 1) step(1);
    rx1 = 1'b0;
    step(20);
    rx1 = 1'b1;
    step(120);
    checks++; if (done1_cnt - d0 !== 0) begin errors++; $display("FAIL glitch_done got %0d exp 0", done1_cnt - d0); end
    checks++; if ({dout1, valid1, ferr1, ovr1} !== {8'hA5, 3'b100}) begin errors++; $display("FAIL glitch_outputs got %h exp %h", {dout1, valid1, ferr1, ovr1}, {8'hA5, 3'b100}); end
  endtask

  task automatic test_frame_err();
    int d0;
    pulse_rd(0);
    checks++; if ({valid1, ovr1} !== 2'b00) begin errors++; $display("FAIL ferr_pop got %b exp 00", {valid1, ovr1}); end
    d0 = done1_cnt;
    send_frame(0, 8'h3C, 8, 1'b0, -1, 1'b0, -1);
    step(8);
    checks++; if (dout1 !== 8'h3C) begin errors++; $display("FAIL ferr_dout got %h exp 3c", dout1); end
    checks++; if ({valid1, ferr1, ovr1} !== 3'b110) begin errors++; $display("FAIL ferr_flags got %b exp 110", {valid1, ferr1, ovr1}); end
    step(800);
    checks++; if (done1_cnt - d0 !== 1) begin errors++; $display("FAIL ferr_break got %0d exp 1", done1_cnt - d0); end
    pulse_rd(0);
    rx1 = 1'b1;
    step(100);
    send_frame(0, 8'h81, 8, 1'b1, -1, 1'b0, -1);
    step(8);
    checks++; if (done1_cnt - d0 !== 2) begin errors++; $display("FAIL ferr_resume got %0d exp 2", done1_cnt - d0); end
    checks++; if ({dout1, ferr1, ovr1} !== {8'h81, 2'b00}) begin errors++; $display("FAIL ferr_next got %h exp %h", {dout1, ferr1, ovr1}, {8'h81, 2'b00}); end
  endtask

  task automatic test_overrun();
    int d0;
    pulse_rd(0);
    d0 = done1_cnt;
    send_frame(0, 8'h11, 8, 1'b1, -1, 1'b0, -1);
    send_frame(0, 8'h22, 8, 1'b1, -1, 1'b0, -1);
    step(8);
    checks++; if (done1_cnt - d0 !== 2) begin errors++; $display("FAIL ovr_done got %0d exp 2", done1_cnt - d0); end
    checks++; if (dout1 !== 8'h22) begin errors++; $display("FAIL ovr_dout got %h exp 22", dout1); end
    checks++; if ({valid1, ovr1} !== 2'b11) begin errors++; $display("FAIL ovr_set got %b exp 11", {valid1, ovr1}); end
    pulse_rd(0);
    checks++; if ({valid1, ovr1} !== 2'b00) begin errors++; $display("FAIL ovr_clear got %b exp 00", {valid1, ovr1}); end
  endtask

  task automatic test_dbit7();
    int d0;
    d0 = done2_cnt;
    send_frame(1, 8'h55, 7, 1'b1, 2, 1'b0, -1);
    step(8);
    checks++; if (done2_cnt - d0 !== 1) begin errors++; $display("FAIL d7_done got %0d exp 1", done2_cnt - d0); end
    checks++; if (dout2 !== 8'h55) begin errors++; $display("FAIL d7_majority got %h exp 55", dout2); end
    send_frame(1, 8'h7F, 7, 1'b1, -1, 1'b1, -1);
    step(8);
    checks++; if (dout2 !== 8'h7F) begin errors++; $display("FAIL d7_coincide_dout got %h exp 7f", dout2); end
    checks++; if ({valid2, ovr2, ferr2} !== 3'b100) begin errors++; $display("FAIL d7_coincide_flags got %b exp 100", {valid2, ovr2, ferr2}); end
  endtask

  task automatic test_reset_midframe();
    int d0;
    send_frame(0, 8'h5A, 8, 1'b1, -1, 1'b0, -1);
    step(8);
    d0 = done1_cnt;
    send_frame(0, 8'hC3, 8, 1'b1, -1, 1'b0, 4);
    checks++; if ({dout1, valid1, done1, ferr1, ovr1} !== 12'h000) begin errors++; $display("FAIL midrst_outputs got %h exp 000", {dout1, valid1, done1, ferr1, ovr1}); end
    checks++; if ({dout2, valid2} !== 9'd0) begin errors++; $display("FAIL midrst_dut7 got %h exp 0", {dout2, valid2}); end
    rx1 = 1'b1;
    step(2);
    reset_n = 1'b1;
    step(700);
    checks++; if (done1_cnt - d0 !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", done1_cnt - d0); end
    send_frame(0, 8'hC3, 8, 1'b1, -1, 1'b0, -1);
    step(8);
    checks++; if (done1_cnt - d0 !== 1) begin errors++; $display("FAIL midrst_next_done got %0d exp 1", done1_cnt - d0); end
    checks++; if ({dout1, valid1, ferr1, ovr1} !== {8'hC3, 3'b100}) begin errors++; $display("FAIL midrst_next got %h exp %h", {dout1, valid1, ferr1, ovr1}, {8'hC3, 3'b100}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch_start();
    test_frame_err();
    test_overrun();
    test_dbit7();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
